decompress_stream: RTL
======================

Name: decompress_stream

Overview:
- Streaming Kyber Decompress_d stage, directly downstream of the ByteDecode block.
- Consumes 4 packed d-bit coefficients per beat over valid/ready.
- Emits 4 coefficients in [0, q-1], q=3329, per beat.
- Frame = 256 coefficients = 64 beats; o_done pulses when the last output beat is accepted.

Parameters:
- LANES, 4, coefficients per beat
- LW, 16, bits per lane on both buses; coefficient in lane bits [11:0], upper bits ignored on input and zero on output
- NCOEF, 256, coefficients per frame

Ports:
- i_clk  input  1  clock, rising-edge
- i_rst  input  1  asynchronous active-high reset
- i_coeffs  input  64  4 lanes; lane k = bits [16k+15:16k]
- i_coeffs_valid  input  1  input beat valid
- o_coeffs_ready  output  1  block accepts input beat
- i_d  input  4  compression width d, sampled at first accepted beat of a frame
- o_coeffs  output  64  4 decompressed lanes
- o_coeffs_valid  output  1  output beat valid
- i_coeffs_ready  input  1  downstream accepts output beat
- o_done  output  1  one-cycle pulse, frame complete

Behaviour:
- Reset (async, i_rst=1): o_coeffs=0, o_coeffs_valid=0, o_done=0, counters=0, state=IDLE. o_coeffs_ready=1 after reset.
- Input accepted when i_coeffs_valid && o_coeffs_ready. Output transferred when o_coeffs_valid && i_coeffs_ready.
- Pipeline: 2 stages. S1 registers 3329*y (23 bits). S2 registers the result. Latency = 2 cycles from accept to o_coeffs_valid with no stall.
- Pipeline enable: en = !o_coeffs_valid || i_coeffs_ready. o_coeffs_ready = en && state!=DONE.
- When en=0, all stages hold. Data and valid never change while o_coeffs_valid=1 && i_coeffs_ready=0.
- Arithmetic, per lane, y = lane[11:0] masked to d bits:
  - d in 1..11: out = (3329*y + 2^(d-1)) >> d. Result is always ≤ 3328.
  - d = 12: pass-through with reduction: out = y ≥ 3329 ? y-3329 : y.
  - d = 0 or 13..15: treated as 12.
- States:
  - IDLE: first accepted beat latches i_d into d_reg. Go to RUN, in_cnt=1.
  - RUN: each accepted beat increments 6-bit in_cnt. Accepting beat 64 stops input: o_coeffs_ready=0 until the frame drains.
  - DONE: entered when the 64th output beat transfers. o_done=1 for exactly that one cycle (registered, asserted the cycle after the transfer). Return to IDLE on the next cycle.
- out_cnt (6 bits) counts output transfers and wraps to 0 after beat 64.
- i_d changes mid-frame are ignored; d_reg governs the whole frame.
- Back-to-back frames: a new frame may be accepted the cycle after o_done.
- i_rst mid-frame: counters, pipeline valids and o_done clear immediately. The partial frame is discarded.

Optional Feature:
- DECOMPRESS_DEBUG_EN defined:
  - Adds output o_coeffs_debug [256*12-1:0]. Coefficient n occupies bits [12(255-n)+11 : 12(255-n)], coefficient 0 MSB-first.
  - Filled as output beats transfer; stable from the o_done pulse until the next frame's first output transfer.
  - Cleared by reset.
- Undefined: port and storage are absent; all other behaviour is identical.

Decomposition:
- kyber_pkg: KYBER_Q=3329, KYBER_N=256, LANES, LW, coefficient width 12, state encodings IDLE/RUN/DONE.
- Sub-module decompress_lane: one lane's 2-stage multiply / round-shift / mod-q pipeline with enable and d input. Instantiated LANES times.
- Control, counters and debug capture stay in the top.

Test Plan:
- d=1, all lanes y=1, 64 beats, ready held 1 -> every lane 1665; first o_coeffs_valid 2 cycles after first accept; o_done 1 cycle after 64th output.
- d=10 lanes {0,1,512,1023} -> {0,3,1665,3326}. d=11 lanes {1,0,2047,1024} -> {2,0,3327,1665}. d=4 y=15 -> 3121.
- d=12 lanes {3328,3329,4095,0} -> {3328,0,766,0}. d=0 behaves identically to d=12.
- Random i_coeffs_ready toggling (50%) over a d=5 frame:
  - o_coeffs stable while stalled;
  - exactly 64 output beats, no loss or duplication;
  - o_coeffs_ready deasserts after 64 accepts until drain.
- i_d changed from 5 to 11 at beat 20 -> whole frame uses d=5. Then a back-to-back second frame with d=11, accepted the cycle after o_done.
- i_rst pulsed at beat 30 -> o_coeffs_valid=0 and o_done=0 immediately. The next full frame completes correctly (with DECOMPRESS_DEBUG_EN, o_coeffs_debug matches the golden vector).

Source files
------------

// File: rtl/kyber_pkg.sv
// kyber_pkg: shared constants, state encoding and d-handling helpers for the
// Kyber decompress stream.
package kyber_pkg;

  localparam int KYBER_Q = 3329;
  localparam int KYBER_N = 256;
  localparam int LANES   = 4;
  localparam int LW      = 16;
  localparam int CW      = 12;
  localparam int PW      = 23;
  localparam int DW      = 4;
  localparam int CNTW    = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Widths 0 and 13..15 have no compressed meaning; they decode as plain 12-bit values.
  function automatic logic [DW-1:0] norm_d(input logic [DW-1:0] d);
    if (d == 4'd0 || d > 4'd12) return 4'd12;
    return d;
  endfunction

  // Low-d-bit mask for a normalised d (1..12).
  function automatic logic [CW-1:0] d_mask(input logic [DW-1:0] d);
    return CW'((13'd1 << d) - 13'd1);
  endfunction

endpackage

// File: rtl/decompress_lane.sv
// decompress_lane: one coefficient lane. Stage 1 holds 3329*y (or y itself for
// d=12), stage 2 holds the rounded shift or the single mod-q subtraction.
module decompress_lane
  import kyber_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_en,
  input  logic [CW-1:0] i_y,
  input  logic [DW-1:0] i_d,
  output logic [CW-1:0] o_coeff
);

  logic [PW-1:0] s1_q, s1_d;
  logic [DW-1:0] d1_q, d1_d;
  logic [CW-1:0] s2_q, s2_d;
  logic [CW-1:0] y_m;
  logic [PW:0]   rnd;
  logic [CW-1:0] shf;

  // Stage 1: mask to d bits and scale by q; d travels with the product.
  always_comb begin
    y_m  = i_y & d_mask(i_d);
    s1_d = s1_q;
    d1_d = d1_q;
    if (i_en) begin
      d1_d = i_d;
      if (i_d == 4'd12) s1_d = PW'(y_m);
      else              s1_d = PW'(y_m) * PW'(KYBER_Q);
    end
  end

  // Stage 2: round-half-up shift by d, or reduce a raw 12-bit value into [0, q-1].
  always_comb begin
    rnd  = {1'b0, s1_q} + ((PW+1)'(1) << (d1_q - 4'd1));
    shf  = CW'(rnd >> d1_q);
    s2_d = s2_q;
    if (i_en) begin
      if (d1_q == 4'd12)
        s2_d = (s1_q[CW-1:0] >= CW'(KYBER_Q)) ? s1_q[CW-1:0] - CW'(KYBER_Q) : s1_q[CW-1:0];
      else
        s2_d = shf;
    end
  end

  // Pipeline registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_q <= '0;
      d1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= s1_d;
      d1_q <= d1_d;
      s2_q <= s2_d;
    end
  end

  assign o_coeff = s2_q;

endmodule

// File: rtl/decompress_stream.sv
// decompress_stream: streaming Kyber Decompress_d, 4 coefficients per beat,
// 64 beats per frame, 2-cycle pipeline with valid/ready back-pressure.
// Build macro DECOMPRESS_DEBUG_EN adds o_coeffs_debug, a capture of the whole
// output frame (coefficient 0 in the top 12 bits).
//
// state | meaning
// IDLE  | waiting for a frame's first beat; i_d is latched when it is accepted
// RUN   | accepting input and draining; input closes after 64 accepts
// DONE  | 64th output beat has transferred; o_done is high for this cycle
module decompress_stream
  import kyber_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [LANES*LW-1:0]   i_coeffs,
  input  logic                  i_coeffs_valid,
  output logic                  o_coeffs_ready,
  input  logic [DW-1:0]         i_d,
  output logic [LANES*LW-1:0]   o_coeffs,
  output logic                  o_coeffs_valid,
  input  logic                  i_coeffs_ready,
  output logic                  o_done
`ifdef DECOMPRESS_DEBUG_EN
  ,
  output logic [KYBER_N*CW-1:0] o_coeffs_debug
`endif
);

  state_e          state_q, state_d;
  logic [CNTW-1:0] in_cnt_q, in_cnt_d;
  logic [CNTW-1:0] out_cnt_q, out_cnt_d;
  logic            in_full_q, in_full_d;
  logic [DW-1:0]   d_reg_q, d_reg_d;
  logic            v1_q, v1_d;
  logic            v2_q, v2_d;

  logic            en, accept, xfer;
  logic [DW-1:0]   d_in, d_lane;
  logic [CW-1:0]   lane_out [LANES];
  logic [LANES-1:0] unused_hi;

  // Handshakes; the first beat of a frame uses i_d directly since d_reg is loaded on that same edge.
  always_comb begin
    en             = !v2_q || i_coeffs_ready;
    o_coeffs_ready = en && (state_q != DONE) && !in_full_q;
    accept         = i_coeffs_valid && o_coeffs_ready;
    xfer           = v2_q && i_coeffs_ready;
    d_in           = norm_d(i_d);
    d_lane         = (state_q == IDLE) ? d_in : d_reg_q;
  end

  // Next-state, counters and pipeline valids.
  always_comb begin
    state_d   = state_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    in_full_d = in_full_q;
    d_reg_d   = d_reg_q;
    v1_d      = v1_q;
    v2_d      = v2_q;
    if (en) begin
      v1_d = accept;
      v2_d = v1_q;
    end
    if (xfer) out_cnt_d = out_cnt_q + 6'd1;
    case (state_q)
      IDLE: begin
        if (accept) begin
          d_reg_d  = d_in;
          in_cnt_d = 6'd1;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (accept) begin
          in_cnt_d = in_cnt_q + 6'd1;
          if (in_cnt_q == 6'd63) in_full_d = 1'b1;
        end
        if (xfer && out_cnt_q == 6'd63) begin
          in_full_d = 1'b0;
          state_d   = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      in_full_q <= 1'b0;
      d_reg_q   <= '0;
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      in_full_q <= in_full_d;
      d_reg_q   <= d_reg_d;
      v1_q      <= v1_d;
      v2_q      <= v2_d;
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    decompress_lane u_lane (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_en    (en),
      .i_y     (i_coeffs[LW*k +: CW]),
      .i_d     (d_lane),
      .o_coeff (lane_out[k])
    );
    assign o_coeffs[LW*k +: LW] = LW'(lane_out[k]);
    assign unused_hi[k]         = ^i_coeffs[LW*k+CW +: LW-CW];
  end

  assign o_coeffs_valid = v2_q;
  assign o_done         = (state_q == DONE);

`ifdef DECOMPRESS_DEBUG_EN
  logic [KYBER_N*CW-1:0] dbg_q, dbg_d;

  // Drop each transferred beat into its slot; coefficient n sits at 12*(255-n).
  always_comb begin
    dbg_d = dbg_q;
    if (xfer) begin
      for (int k = 0; k < LANES; k++)
        dbg_d[CW*(KYBER_N-1-(int'(out_cnt_q)*LANES+k)) +: CW] = lane_out[k];
    end
  end

  // Debug capture register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) dbg_q <= '0;
    else       dbg_q <= dbg_d;
  end

  assign o_coeffs_debug = dbg_q;
`endif

endmodule
